// File: rtl/mult_result_checker.sv
// mult_result_checker: shift-add golden multiplier that checks a candidate product and keeps saturating pass/fail tallies.
// Optional first-failure capture ports are enabled by defining MULT_CHK_CAPTURE_EN.
module mult_result_checker #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   p,
  output logic             busy,
  output logic             done_valid,
  output logic             match,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
`ifdef MULT_CHK_CAPTURE_EN
  ,
  output logic             fail_seen,
  output logic [W-1:0]     fail_a,
  output logic [W-1:0]     fail_b,
  output logic [2*W-1:0]   fail_p,
  output logic [2*W-1:0]   fail_exp
`endif
);
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] CMP  = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ma_q, ma_d, acc_q, acc_d, pl_q, pl_d;
  logic [W-1:0]     mb_q, mb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d, match_q, match_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
`ifdef MULT_CHK_CAPTURE_EN
  logic             fs_q, fs_d;
  logic [W-1:0]     al_q, al_d, bl_q, bl_d, fa_q, fa_d, fb_q, fb_d;
  logic [PW-1:0]    fp_q, fp_d, fe_q, fe_d;
  assign fail_seen = fs_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  assign fail_p    = fp_q;
  assign fail_exp  = fe_q;
`endif
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == CALC) || (state_q == CMP);
  assign done_valid = done_q;
  assign match      = match_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  // Next state: clear beats accept, accept beats FSM progress; CALC retires one multiplier bit per edge.
  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    pl_d    = pl_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    match_d = match_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
`ifdef MULT_CHK_CAPTURE_EN
    fs_d = fs_q;
    al_d = al_q;
    bl_d = bl_q;
    fa_d = fa_q;
    fb_d = fb_q;
    fp_d = fp_q;
    fe_d = fe_q;
`endif
    if (clear) begin
      state_d = IDLE;
      ma_d    = '0;
      mb_d    = '0;
      pl_d    = '0;
      acc_d   = '0;
      cnt_d   = '0;
      match_d = 1'b0;
      pass_d  = '0;
      fail_d  = '0;
`ifdef MULT_CHK_CAPTURE_EN
      fs_d = 1'b0;
      al_d = '0;
      bl_d = '0;
      fa_d = '0;
      fb_d = '0;
      fp_d = '0;
      fe_d = '0;
`endif
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        state_d = CALC;
        ma_d    = {{W{1'b0}}, a};
        mb_d    = b;
        pl_d    = p;
        acc_d   = '0;
        cnt_d   = '0;
`ifdef MULT_CHK_CAPTURE_EN
        al_d = a;
        bl_d = b;
`endif
      end
    end else if (state_q == CALC) begin
      acc_d   = mb_q[0] ? acc_q + ma_q : acc_q;
      ma_d    = ma_q << 1;
      mb_d    = mb_q >> 1;
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(W - 1)) ? CMP : CALC;
    end else begin
      state_d = IDLE;
      done_d  = 1'b1;
      match_d = (acc_q == pl_q);
      pass_d  = (acc_q == pl_q && !(&pass_q)) ? pass_q + 1'b1 : pass_q;
      fail_d  = (acc_q != pl_q && !(&fail_q)) ? fail_q + 1'b1 : fail_q;
`ifdef MULT_CHK_CAPTURE_EN
      if (acc_q != pl_q && !fs_q) begin
        fs_d = 1'b1;
        fa_d = al_q;
        fb_d = bl_q;
        fp_d = pl_q;
        fe_d = acc_q;
      end
`endif
    end
  end
  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      pl_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
`ifdef MULT_CHK_CAPTURE_EN
      fs_q <= 1'b0;
      al_q <= '0;
      bl_q <= '0;
      fa_q <= '0;
      fb_q <= '0;
      fp_q <= '0;
      fe_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      pl_q    <= pl_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      match_q <= match_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
`ifdef MULT_CHK_CAPTURE_EN
      fs_q <= fs_d;
      al_q <= al_d;
      bl_q <= bl_d;
      fa_q <= fa_d;
      fb_q <= fb_d;
      fp_q <= fp_d;
      fe_q <= fe_d;
`endif
    end
  end
endmodule

// File: tb/tb_mult_result_checker.sv
// tb_mult_result_checker: scoreboard bench; expected match/latency queued at accept, popped on done_valid.
module tb_mult_result_checker;
  localparam int W  = 8;
  localparam int PW = 2 * W;
  logic clk = 1'b0;
  logic rst_n, clear, in_valid;
  logic [W-1:0] a, b;
  logic [PW-1:0] p;
  logic in_ready, busy, done_valid, match;
  logic in_ready2, busy2, done2, match2;
  logic [15:0] pass_cnt, fail_cnt;
  logic [1:0] pass2, fail2;
`ifdef MULT_CHK_CAPTURE_EN
  logic fail_seen, fs2;
  logic [W-1:0] fail_a, fail_b, fa2, fb2;
  logic [PW-1:0] fail_p, fail_exp, fp2, fe2;
  logic e_fs;
  logic [W-1:0] e_fa, e_fb;
  logic [PW-1:0] e_fp, e_fe;
`endif
  int n_chk = 0, n_pass = 0, cyc = 0;
  int first_acc, last_done, idx;
  int exp_pass, exp_fail, exp_pass2, exp_fail2;
  bit qm[$];
  int qe[$];
  logic [W-1:0] ra, rb;
  logic [PW-1:0] rp;
  logic [W-1:0] ta [4];
  logic [W-1:0] tbv [4];

  always #5 clk = ~clk;

  mult_result_checker #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .p(p), .busy(busy), .done_valid(done_valid), .match(match),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`ifdef MULT_CHK_CAPTURE_EN
    , .fail_seen(fail_seen), .fail_a(fail_a), .fail_b(fail_b), .fail_p(fail_p), .fail_exp(fail_exp)
`endif
  );

  mult_result_checker #(.W(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .p(p), .busy(busy2), .done_valid(done2), .match(match2),
    .pass_cnt(pass2), .fail_cnt(fail2)
`ifdef MULT_CHK_CAPTURE_EN
    , .fail_seen(fs2), .fail_a(fa2), .fail_b(fb2), .fail_p(fp2), .fail_exp(fe2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_zero();
    qm.delete();
    qe.delete();
    exp_pass = 0;
    exp_fail = 0;
    exp_pass2 = 0;
    exp_fail2 = 0;
`ifdef MULT_CHK_CAPTURE_EN
    e_fs = 1'b0;
    e_fa = '0;
    e_fb = '0;
    e_fp = '0;
    e_fe = '0;
`endif
  endtask

  // One clock: predict acceptance from the inputs about to be sampled, then check any done_valid.
  task automatic tick();
    logic [PW-1:0] g;
    if (clear && rst_n) model_zero();
    else if (in_valid && in_ready && rst_n) begin
      g = PW'(a) * PW'(b);
      qm.push_back(g == p);
      qe.push_back(cyc + W + 2);
      if (g == p) begin
        exp_pass  = exp_pass + 1;
        exp_pass2 = (exp_pass2 == 3) ? 3 : exp_pass2 + 1;
      end else begin
        exp_fail  = exp_fail + 1;
        exp_fail2 = (exp_fail2 == 3) ? 3 : exp_fail2 + 1;
`ifdef MULT_CHK_CAPTURE_EN
        if (!e_fs) begin
          e_fs = 1'b1;
          e_fa = a;
          e_fb = b;
          e_fp = p;
          e_fe = g;
        end
`endif
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (done_valid) begin
      last_done = cyc;
      if (qm.size() == 0) check("spurious_done", 1, 0);
      else begin
        check("match", match, qm.pop_front());
        check("latency", cyc, qe.pop_front());
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * W && qm.size() > 0; i++) tick();
    check("drain_timeout", qm.size(), 0);
  endtask

  task automatic counts();
    check("pass_cnt", pass_cnt, exp_pass);
    check("fail_cnt", fail_cnt, exp_fail);
    check("pass_cnt_sat", pass2, exp_pass2);
    check("fail_cnt_sat", fail2, exp_fail2);
`ifdef MULT_CHK_CAPTURE_EN
    check("fail_seen", fail_seen, e_fs);
    check("fail_a", fail_a, e_fa);
    check("fail_b", fail_b, e_fb);
    check("fail_p", fail_p, e_fp);
    check("fail_exp", fail_exp, e_fe);
`endif
  endtask

  task automatic run(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [PW-1:0] xp);
    a = xa;
    b = xb;
    p = xp;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", in_ready, 0);
    a = ~xa;
    b = ~xb;
    p = ~xp;
    drain();
    counts();
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    p = '0;
    model_zero();
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done_valid, 0);
    check("rst_match", match, 0);
    counts();
    rst_n = 1'b1;
    tick();
    run(8'd3, 8'd5, 16'd15);
    run(8'd255, 8'd255, 16'hFE01);
    run(8'd255, 8'd255, 16'hFE00);
    run(8'd0, 8'd173, 16'd0);
    run(8'd91, 8'd0, 16'd5);
    run(8'd17, 8'd33, 16'd560);
    repeat (6) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rp = PW'(ra) * PW'(rb);
      if ($urandom_range(1) == 1) rp = rp ^ (PW'(1) << $urandom_range(PW - 1));
      run(ra, rb, rp);
    end
    ta  = '{8'd7, 8'd200, 8'd0, 8'd128};
    tbv = '{8'd9, 8'd3, 8'd77, 8'd255};
    idx = 0;
    first_acc = -1;
    for (int i = 0; i < 80 && (idx < 4 || qm.size() > 0); i++) begin
      if (idx < 4) begin
        in_valid = 1'b1;
        if (in_ready) begin
          if (idx > 0) check("accept_in_done_cycle", done_valid, 1);
          a = ta[idx];
          b = tbv[idx];
          p = PW'(ta[idx]) * PW'(tbv[idx]);
          if (idx == 0) first_acc = cyc + 1;
          idx++;
        end else begin
          check("busy_while_not_ready", busy, 1);
          a = W'($urandom);
          b = W'($urandom);
          p = PW'($urandom);
        end
      end else in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    check("b2b_span", last_done - first_acc, 3 * (W + 2) + W + 1);
    drain();
    counts();
    a = 8'd9;
    b = 8'd9;
    p = 16'd81;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    in_valid = 1'b1;
    a = 8'd2;
    b = 8'd2;
    p = 16'd4;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_ready", in_ready, 1);
    check("clear_busy", busy, 0);
    check("clear_done", done_valid, 0);
    check("clear_match", match, 0);
    counts();
    clear = 1'b1;
    in_valid = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_blocks_accept", busy, 0);
    repeat (W + 4) tick();
    for (int i = 0; i < 5; i++) run(W'(i + 1), W'(3 * i + 2), PW'(i + 1) * PW'(3 * i + 2));
    check("sat_pass_final", pass2, 3);
    check("sat_fail_final", fail2, 0);
    run(8'd12, 8'd12, 16'd145);
    a = 8'd200;
    b = 8'd100;
    p = 16'd20000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 1);
    check("arst_done", done_valid, 0);
    model_zero();
    counts();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) tick();
    run(8'd10, 8'd20, 16'd200);
    check("sb_empty", qm.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
